// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2,
        S_LAP  = 2'd3
    } sw_state_t;

    localparam int DEF_TICK_DIV = 500_000;

    // Press-vector indices; a lower index takes priority when keys collide
    localparam int KEY_CLEAR = 0;
    localparam int KEY_START = 1;
    localparam int KEY_LAP   = 2;
    localparam int NUM_KEYS  = 3;

endpackage

// File: rtl/key_press_det.sv
// One key: 2-flop synchronizer, previous-value flop and one-cycle press pulse
// on each released-to-pressed (1->0) transition.
module key_press_det (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic sync1, sync2, prev;

    // Reset to the released level so no press appears on reset release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = prev & ~sync2;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/lap sequencer with gated count-tick prescaler.
// Define STOPWATCH_LAP_EN to enable the lap key, LAP state and hold output.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start,
    input  logic       key_clear,
    input  logic       key_lap,
    output logic       run,
    output logic       tick,
    output logic       clr,
    output logic       hold,
    output logic [1:0] state
);

    logic [NUM_KEYS-1:0] press;
    sw_state_t           st, nxt;
    logic                do_clr;
    logic [CNT_W-1:0]    cnt;

    key_press_det u_start (.clk(clk), .rst_n(rst_n), .key_n(key_start), .press(press[KEY_START]));
    key_press_det u_clear (.clk(clk), .rst_n(rst_n), .key_n(key_clear), .press(press[KEY_CLEAR]));

`ifdef STOPWATCH_LAP_EN
    key_press_det u_lap   (.clk(clk), .rst_n(rst_n), .key_n(key_lap),   .press(press[KEY_LAP]));
`else
    logic unused_lap;
    assign unused_lap     = key_lap;
    assign press[KEY_LAP] = 1'b0;
`endif

    // Each state tests only the keys it honours, highest priority first
    always_comb begin
        nxt    = st;
        do_clr = 1'b0;
        case (st)
            S_IDLE: begin
                if (press[KEY_CLEAR])      do_clr = 1'b1;
                else if (press[KEY_START]) nxt    = S_RUN;
            end
            S_RUN: begin
                if (press[KEY_START])      nxt = S_STOP;
                else if (press[KEY_LAP])   nxt = S_LAP;
            end
            S_STOP: begin
                if (press[KEY_CLEAR]) begin
                    nxt    = S_IDLE;
                    do_clr = 1'b1;
                end else if (press[KEY_START]) begin
                    nxt    = S_RUN;
                end
            end
            S_LAP: begin
                if (press[KEY_START])      nxt = S_STOP;
                else if (press[KEY_LAP])   nxt = S_RUN;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st   <= S_IDLE;
            run  <= 1'b0;
            hold <= 1'b0;
            clr  <= 1'b0;
            tick <= 1'b0;
            cnt  <= '0;
        end else begin
            st   <= nxt;
            run  <= (nxt == S_RUN) || (nxt == S_LAP);
`ifdef STOPWATCH_LAP_EN
            hold <= (nxt == S_LAP);
`else
            hold <= 1'b0;
`endif
            clr  <= do_clr;
            tick <= 1'b0;
            // Prescaler keeps its count while stopped so a partial interval resumes
            if (clr) begin
                cnt <= '0;
            end else if (run) begin
                if (cnt == CNT_W'(TICK_DIV - 1)) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=4: expected tick/clr cycles
// are queued as keys are pressed and retired as the DUT pulses.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, key_start, key_clear, key_lap;
    logic       run, tick, clr, hold;
    logic [1:0] state;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int exp_tick[$];
    int exp_clr[$];

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_clear(key_clear),
        .key_lap(key_lap), .run(run), .tick(tick), .clr(clr), .hold(hold), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Advance to the next falling edge and retire scoreboard entries due now
    task automatic step();
        @(negedge clk);
        if (tick) begin
            checks++;
            if (exp_tick.size() == 0 || exp_tick[0] != cyc) begin
                failures++;
                $display("FAIL tick_unexpected cyc=%0d got=1 exp=0", cyc);
            end else void'(exp_tick.pop_front());
        end else if (exp_tick.size() != 0 && exp_tick[0] == cyc) begin
            checks++; failures++;
            $display("FAIL tick_missing cyc=%0d got=0 exp=1", cyc);
            void'(exp_tick.pop_front());
        end
        if (clr) begin
            checks++;
            if (exp_clr.size() == 0 || exp_clr[0] != cyc) begin
                failures++;
                $display("FAIL clr_unexpected cyc=%0d got=1 exp=0", cyc);
            end else void'(exp_clr.pop_front());
        end else if (exp_clr.size() != 0 && exp_clr[0] == cyc) begin
            checks++; failures++;
            $display("FAIL clr_missing cyc=%0d got=0 exp=1", cyc);
            void'(exp_clr.pop_front());
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    // m[0]=start m[1]=clear m[2]=lap; keys fall now, sampled at the next edge
    task automatic press(input logic [2:0] m);
        key_start = ~m[0];
        key_clear = ~m[1];
        key_lap   = ~m[2];
        step();
        key_start = 1'b1;
        key_clear = 1'b1;
        key_lap   = 1'b1;
    endtask

    task automatic do_reset();
        checks++;
        if (exp_tick.size() != 0 || exp_clr.size() != 0) begin
            failures++;
            $display("FAIL pending_events got=%0d exp=0", exp_tick.size() + exp_clr.size());
        end
        exp_tick.delete();
        exp_clr.delete();
        rst_n = 1'b0;
        step();
        checks++;
        if ({state, run, tick, clr, hold} !== 6'b0) begin
            failures++;
            $display("FAIL midop_reset got=%b exp=000000", {state, run, tick, clr, hold});
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_start = 1'b1; key_clear = 1'b1; key_lap = 1'b1;
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({state, run, tick, clr, hold} !== 6'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=000000", cyc, {state, run, tick, clr, hold});
            end
        end
    endtask

    task automatic test_run_ticks();
        int k;
        k = cyc + 1;
        exp_tick.push_back(k + 6);
        exp_tick.push_back(k + 10);
        exp_tick.push_back(k + 14);
        press(3'b001);
        wait_until(k + 1);
        checks++;
        if (run !== 1'b0) begin failures++; $display("FAIL run_latency_early got=%b exp=0", run); end
        wait_until(k + 2);
        checks++;
        if (state !== 2'd1 || run !== 1'b1 || hold !== 1'b0) begin
            failures++;
            $display("FAIL run_entry got=%0d/%b/%b exp=1/1/0", state, run, hold);
        end
        wait_until(k + 17);
        do_reset();
    endtask

    task automatic test_resume();
        int k1, k2, k3;
        k1 = cyc + 1;
        exp_tick.push_back(k1 + 6);
        press(3'b001);
        wait_until(k1 + 5);
        k2 = cyc + 1;
        press(3'b001);
        wait_until(k2 + 2);
        checks++;
        if (state !== 2'd2 || run !== 1'b0) begin
            failures++;
            $display("FAIL stop_entry got=%0d/%b exp=2/0", state, run);
        end
        wait_until(k2 + 9);
        k3 = cyc + 1;
        exp_tick.push_back(k3 + 4);
        press(3'b001);
        wait_until(k3 + 2);
        checks++;
        if (state !== 2'd1 || run !== 1'b1) begin
            failures++;
            $display("FAIL resume_run got=%0d/%b exp=1/1", state, run);
        end
        wait_until(k3 + 7);
        do_reset();
    endtask

    task automatic test_clear();
        int k1, k3, k4, k5;
        k1 = cyc + 1;
        press(3'b001);
        wait_until(k1 + 2);
        press(3'b001);
        wait_until(k1 + 5);
        checks++;
        if (state !== 2'd2) begin failures++; $display("FAIL clear_pre_stop got=%0d exp=2", state); end
        wait_until(k1 + 6);
        k3 = cyc + 1;
        exp_clr.push_back(k3 + 2);
        press(3'b010);
        wait_until(k3 + 2);
        checks++;
        if (state !== 2'd0 || run !== 1'b0) begin
            failures++;
            $display("FAIL clear_to_idle got=%0d/%b exp=0/0", state, run);
        end
        wait_until(k3 + 3);
        k4 = cyc + 1;
        exp_tick.push_back(k4 + 6);
        exp_tick.push_back(k4 + 10);
        press(3'b001);
        wait_until(k4 + 3);
        k5 = cyc + 1;
        press(3'b010);
        wait_until(k5 + 2);
        checks++;
        if (state !== 2'd1 || run !== 1'b1) begin
            failures++;
            $display("FAIL clear_ignored_in_run got=%0d/%b exp=1/1", state, run);
        end
        wait_until(k4 + 11);
        do_reset();
    endtask

    task automatic test_lap();
        int k1, k2, k3;
        logic [1:0] exp_st;
        logic       exp_hold;
`ifdef STOPWATCH_LAP_EN
        exp_st = 2'd3; exp_hold = 1'b1;
`else
        exp_st = 2'd1; exp_hold = 1'b0;
`endif
        k1 = cyc + 1;
        exp_tick.push_back(k1 + 6);
        exp_tick.push_back(k1 + 10);
        press(3'b001);
        wait_until(k1 + 2);
        k2 = cyc + 1;
        press(3'b100);
        wait_until(k2 + 2);
        checks++;
        if (state !== exp_st || hold !== exp_hold || run !== 1'b1) begin
            failures++;
            $display("FAIL lap_enter got=%0d/%b/%b exp=%0d/%b/1", state, hold, run, exp_st, exp_hold);
        end
        wait_until(k1 + 7);
        k3 = cyc + 1;
        press(3'b100);
        wait_until(k3 + 2);
        checks++;
        if (state !== 2'd1 || hold !== 1'b0 || run !== 1'b1) begin
            failures++;
            $display("FAIL lap_exit got=%0d/%b/%b exp=1/0/1", state, hold, run);
        end
        wait_until(k1 + 11);
        do_reset();
    endtask

    task automatic test_simultaneous();
        int k1, k3;
        k1 = cyc + 1;
        press(3'b001);
        wait_until(k1 + 2);
        press(3'b001);
        wait_until(k1 + 6);
        k3 = cyc + 1;
        exp_clr.push_back(k3 + 2);
        press(3'b111);
        wait_until(k3 + 2);
        checks++;
        if (state !== 2'd0 || run !== 1'b0 || hold !== 1'b0) begin
            failures++;
            $display("FAIL simul_clear_wins got=%0d/%b/%b exp=0/0/0", state, run, hold);
        end
        wait_until(k3 + 8);
        checks++;
        if (state !== 2'd0 || run !== 1'b0) begin
            failures++;
            $display("FAIL simul_no_queue got=%0d/%b exp=0/0", state, run);
        end
        do_reset();
    endtask

    task automatic test_held_through_reset();
        int e;
        rst_n = 1'b0;
        key_start = 1'b0;
        step(); step();
        rst_n = 1'b1;
        e = cyc;
        wait_until(e + 2);
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL held_early got=%0d exp=0", state); end
        exp_tick.push_back(e + 7);
        exp_tick.push_back(e + 11);
        wait_until(e + 3);
        checks++;
        if (state !== 2'd1 || run !== 1'b1) begin
            failures++;
            $display("FAIL held_press got=%0d/%b exp=1/1", state, run);
        end
        wait_until(e + 12);
        key_start = 1'b1;
        wait_until(e + 14);
        checks++;
        if (state !== 2'd1) begin failures++; $display("FAIL held_single_press got=%0d exp=1", state); end
        do_reset();
    endtask

    initial begin
        rst_n = 1'b0; key_start = 1'b1; key_clear = 1'b1; key_lap = 1'b1;
        test_reset();
        test_run_ticks();
        test_resume();
        test_clear();
        test_lap();
        test_simultaneous();
        test_held_through_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
